// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared control-path types for the RV32I cores (multi-cycle and single-cycle).
// Contents:
//   ctrl_state_t  - multi-cycle controller state encoding (4-bit)
//   alu_ctrl_t    - ALU operation select driven onto ALUControl
//   imm_src_t     - immediate format select
//   result_src_t  - Result bus source select
//   srca_t/srcb_t - ALU operand selects
//   alu_op_t      - coarse ALU class handed from the FSM to the ALU decoder
//   opcode / funct3 localparams and a request-state helper

package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JALRADR  = 4'd10,
        ST_JUMP     = 4'd11,
        ST_LUI      = 4'd12,
        ST_FAULT    = 4'd13
    } ctrl_state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_LUI = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_B = 3'b001,
        IMM_S = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_t;

    // ALUOP_FUNCT defers the choice to funct3/funct7; the others are fixed.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_LUI   = 2'b11
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // States that hold a request open to the unified memory.
    function automatic logic is_mem_request_state(input ctrl_state_t s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational translation of the FSM's coarse ALU class into ALUControl.
// Ports:
//   alu_op      in   ALU class from the controller FSM
//   funct3      in   IR[14:12]
//   funct7      in   IR[30]
//   op5         in   IR[5]; distinguishes R-type (SUB possible) from I-type
//   alu_control out  ALU operation select

module alu_decoder
    import core_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        op5,
    output alu_ctrl_t   alu_control
);

    // Unsupported funct3 codes quietly fall back to ADD rather than faulting.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_LUI: alu_control = ALU_LUI;
            ALUOP_FUNCT: begin
                case (funct3)
                    F3_ADD:  alu_control = (funct7 && op5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_control = ALU_SLL;
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the multi-cycle RV32I core (shared ALU, unified memory).
// Steps the datapath one state per cycle, handles the memory ready handshake
// with a wait-cycle timeout, raises a sticky fault and counts retirements.
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   op_i/funct3_i/funct7_i  instruction fields from the IR
//   Zero_i                ALU zero flag (same cycle)
//   mem_ready_i           memory completes the current request
//   MemReq_o/MemWrite_o/AdrSrc_o      memory request controls
//   IRWrite_o/PCWrite_o/RegWrite_o    architectural write strobes
//   ALUSrcA_o/ALUSrcB_o/ALUControl_o/ImmSrc_o/ResultSrc_o  datapath selects
//   InstrRetired_o/RetireCount_o      retire pulse and wrapping count
//   Fault_o               sticky fault flag

module multicycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          op_i,
    input  logic [2:0]          funct3_i,
    input  logic                funct7_i,
    input  logic                Zero_i,
    input  logic                mem_ready_i,
    output logic                MemReq_o,
    output logic                MemWrite_o,
    output logic                AdrSrc_o,
    output logic                IRWrite_o,
    output logic                PCWrite_o,
    output logic                RegWrite_o,
    output logic [1:0]          ALUSrcA_o,
    output logic [1:0]          ALUSrcB_o,
    output logic [2:0]          ALUControl_o,
    output logic [2:0]          ImmSrc_o,
    output logic [1:0]          ResultSrc_o,
    output logic                InstrRetired_o,
    output logic [RETIRE_W-1:0] RetireCount_o,
    output logic                Fault_o
);

    localparam logic                 TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    ctrl_state_t          state;
    ctrl_state_t          state_next;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] wait_cnt_next;
    logic                 timeout_hit;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        retired;
    srca_t       srca;
    srcb_t       srcb;
    alu_op_t     alu_op;
    imm_src_t    imm_src;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3_i),
        .funct7      (funct7_i),
        .op5         (op_i[5]),
        .alu_control (alu_ctrl)
    );

    // A request that reaches the wait limit without ready is abandoned.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_LIMIT) && !mem_ready_i;

    // State register and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Retire counter; wraps naturally at 2^RETIRE_W.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RetireCount_o <= '0;
        end else if (retired) begin
            RetireCount_o <= RetireCount_o + 1'b1;
        end
    end

    // The wait counter only runs while a request stays open and unanswered.
    always_comb begin
        wait_cnt_next = '0;
        if (is_mem_request_state(state) && !mem_ready_i && (state_next == state)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retired    = 1'b0;
        srca       = SRCA_PC;
        srcb       = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;

        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    // PC+4 goes straight from the ALU onto the Result bus.
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    srcb       = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end

            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                srca    = SRCA_OLDPC;
                srcb    = SRCB_IMM;
                imm_src = IMM_B;
                case (op_i)
                    OP_LOAD, OP_STORE: state_next = ST_MEMADR;
                    OP_RTYPE:          state_next = ST_EXECR;
                    OP_ITYPE:          state_next = ST_EXECI;
                    OP_BRANCH: begin
                        if ((funct3_i == F3_BEQ) || (funct3_i == F3_BNE)) begin
                            state_next = ST_BRANCH;
                        end else begin
                            state_next = ST_FAULT;
                        end
                    end
                    OP_JAL:            state_next = ST_JUMP;
                    OP_JALR:           state_next = ST_JALRADR;
                    OP_LUI:            state_next = ST_LUI;
                    default:           state_next = ST_FAULT;
                endcase
            end

            ST_MEMADR: begin
                srca       = SRCA_RD1;
                srcb       = SRCB_IMM;
                imm_src    = op_i[5] ? IMM_S : IMM_I;
                state_next = op_i[5] ? ST_MEMWRITE : ST_MEMREAD;
            end

            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready_i) begin
                    state_next = ST_MEMWB;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end

            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                retired    = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready_i) begin
                    retired    = 1'b1;
                    state_next = ST_FETCH;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end

            ST_EXECR: begin
                srca       = SRCA_RD1;
                srcb       = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end

            ST_EXECI: begin
                srca       = SRCA_RD1;
                srcb       = SRCB_IMM;
                imm_src    = IMM_I;
                alu_op     = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end

            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retired    = 1'b1;
                state_next = ST_FETCH;
            end

            ST_BRANCH: begin
                // funct3[0] inverts the sense: BEQ takes on zero, BNE on non-zero.
                srca       = SRCA_RD1;
                srcb       = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = Zero_i ^ funct3_i[0];
                retired    = 1'b1;
                state_next = ST_FETCH;
            end

            ST_JALRADR: begin
                srca       = SRCA_RD1;
                srcb       = SRCB_IMM;
                imm_src    = IMM_I;
                state_next = ST_JUMP;
            end

            ST_JUMP: begin
                // Target from ALUOut into PC while the ALU forms OldPC+4 for rd.
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
                srca       = SRCA_OLDPC;
                srcb       = SRCB_FOUR;
                state_next = ST_ALUWB;
            end

            ST_LUI: begin
                srca       = SRCA_RD1;
                srcb       = SRCB_IMM;
                imm_src    = IMM_U;
                alu_op     = ALUOP_LUI;
                state_next = ST_ALUWB;
            end

            ST_FAULT: begin
                state_next = ST_FAULT;
            end

            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Everything is forced quiet while reset is held so an in-flight
    // request is dropped without a partial write.
    assign MemReq_o       = mem_req   & ~rst_i;
    assign MemWrite_o     = mem_write & ~rst_i;
    assign AdrSrc_o       = adr_src   & ~rst_i;
    assign IRWrite_o      = ir_write  & ~rst_i;
    assign PCWrite_o      = pc_write  & ~rst_i;
    assign RegWrite_o     = reg_write & ~rst_i;
    assign InstrRetired_o = retired   & ~rst_i;
    assign ALUSrcA_o      = rst_i ? 2'b00 : srca;
    assign ALUSrcB_o      = rst_i ? 2'b00 : srcb;
    assign ALUControl_o   = rst_i ? 3'b000 : alu_ctrl;
    assign ImmSrc_o       = rst_i ? 3'b000 : imm_src;
    assign ResultSrc_o    = rst_i ? 2'b00 : result_src;
    assign Fault_o        = (state == ST_FAULT) & ~rst_i;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Cycle-by-cycle vectors: each record names the inputs and the expected
// controller phase; the expected outputs for that phase are built by a
// small reference function and queued, then popped and compared at the
// falling edge. The retire count is tracked by a bench-side counter.

module tb_multicycle_controller;

    typedef enum int {
        S_RST, S_F, S_FR, S_D, S_MA, S_MR, S_MWB, S_MW, S_MWR,
        S_XR, S_XI, S_AWB, S_BR, S_JA, S_J, S_LUI, S_FLT
    } tb_st_e;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       ready;
        tb_st_e     st;
    } vec_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [2:0] imm;
        logic [1:0] res;
        logic       retired;
        logic       fault;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic [31:0] cnt;
    } sb_t;

    localparam logic [6:0] OPR    = 7'h33;
    localparam logic [6:0] OPI    = 7'h13;
    localparam logic [6:0] OPLD   = 7'h03;
    localparam logic [6:0] OPST   = 7'h23;
    localparam logic [6:0] OPBR   = 7'h63;
    localparam logic [6:0] OPJAL  = 7'h6F;
    localparam logic [6:0] OPJALR = 7'h67;
    localparam logic [6:0] OPLUI  = 7'h37;
    localparam logic [6:0] OPBAD  = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  srca, srcb, res_src;
    logic [2:0]  alu_ctrl, imm_src;
    logic        retired;
    logic [31:0] retire_count;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;
    sb_t         sb[$];
    vec_t        cur_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_W      (8),
        .RETIRE_W       (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .op_i           (op),
        .funct3_i       (f3),
        .funct7_i       (f7),
        .Zero_i         (zero),
        .mem_ready_i    (ready),
        .MemReq_o       (mem_req),
        .MemWrite_o     (mem_write),
        .AdrSrc_o       (adr_src),
        .IRWrite_o      (ir_write),
        .PCWrite_o      (pc_write),
        .RegWrite_o     (reg_write),
        .ALUSrcA_o      (srca),
        .ALUSrcB_o      (srcb),
        .ALUControl_o   (alu_ctrl),
        .ImmSrc_o       (imm_src),
        .ResultSrc_o    (res_src),
        .InstrRetired_o (retired),
        .RetireCount_o  (retire_count),
        .Fault_o        (fault)
    );

    // Expected ALUControl for EXECR/EXECI from the funct fields.
    function automatic logic [2:0] exp_alu(input vec_t v);
        case (v.f3)
            3'b000:  return (v.f7 && v.op[5]) ? 3'b001 : 3'b000;
            3'b001:  return 3'b110;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Reference outputs for each controller phase.
    function automatic outs_t expect_outs(input vec_t v);
        outs_t e;
        e = '0;
        case (v.st)
            S_RST: ;
            S_F:   e.mem_req = 1'b1;
            S_FR:  begin
                e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
                e.srcb = 2'b10; e.res = 2'b10;
            end
            S_D:   begin e.srca = 2'b01; e.srcb = 2'b01; e.imm = 3'b001; end
            S_MA:  begin
                e.srca = 2'b10; e.srcb = 2'b01; e.imm = v.op[5] ? 3'b010 : 3'b000;
            end
            S_MR:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            S_MWB: begin e.res = 2'b01; e.reg_write = 1'b1; e.retired = 1'b1; end
            S_MW:  begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
            S_MWR: begin
                e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; e.retired = 1'b1;
            end
            S_XR:  begin e.srca = 2'b10; e.alu = exp_alu(v); end
            S_XI:  begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = exp_alu(v); end
            S_AWB: begin e.reg_write = 1'b1; e.retired = 1'b1; end
            S_BR:  begin
                e.srca = 2'b10; e.alu = 3'b001; e.retired = 1'b1;
                e.pc_write = v.zero ^ v.f3[0];
            end
            S_JA:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            S_J:   begin e.pc_write = 1'b1; e.srca = 2'b01; e.srcb = 2'b10; end
            S_LUI: begin e.srca = 2'b10; e.srcb = 2'b01; e.imm = 3'b011; e.alu = 3'b100; end
            S_FLT: e.fault = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_vec(input logic r, input logic [6:0] o, input logic [2:0] fn3,
                            input logic fn7, input logic z, input logic rdy, input tb_st_e s);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = fn3; v.f7 = fn7; v.zero = z; v.ready = rdy; v.st = s;
        cur_q.push_back(v);
    endtask

    task automatic checkOutput(input string label, input int idx, input tb_st_e st);
        sb_t   e;
        outs_t act;
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               srca, srcb, alu_ctrl, imm_src, res_src, retired, fault};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard %0s #%0d empty queue actual=%05h", label, idx, act);
            return;
        end
        e = sb.pop_front();
        if (act !== e.o) begin
            errors++;
            $display("[TB] FAIL outs %0s #%0d %s actual=%05h required=%05h",
                     label, idx, st.name(), act, e.o);
        end
        checks++;
        if (retire_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL retire_count %0s #%0d %s actual=%0d required=%0d",
                     label, idx, st.name(), retire_count, e.cnt);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string label, input int idx);
        outs_t e;
        @(posedge clk);
        #1;
        rst = v.rst; op = v.op; f3 = v.f3; f7 = v.f7; zero = v.zero; ready = v.ready;
        e = expect_outs(v);
        sb.push_back('{o: e, cnt: exp_cnt});
        @(negedge clk);
        checkOutput(label, idx, v.st);
        if (v.rst) exp_cnt = '0;
        else if (e.retired) exp_cnt = exp_cnt + 1;
    endtask

    task automatic run_queue(input string label);
        for (int i = 0; i < cur_q.size(); i++) applyStimulus(cur_q[i], label, i);
        cur_q.delete();
    endtask

    initial begin
        rst = 1'b1; op = OPR; f3 = '0; f7 = 1'b0; zero = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);

        // Main table: zero-wait instructions plus stalls at the wait limit.
        push_vec(1, OPR, 3'b000, 0, 0, 1, S_RST);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_FR);  push_vec(0, OPR, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_XR);  push_vec(0, OPR, 3'b000, 0, 0, 1, S_AWB);
        push_vec(0, OPR, 3'b000, 1, 0, 1, S_FR);  push_vec(0, OPR, 3'b000, 1, 0, 1, S_D);
        push_vec(0, OPR, 3'b000, 1, 0, 1, S_XR);  push_vec(0, OPR, 3'b000, 1, 0, 0, S_AWB);
        push_vec(0, OPI, 3'b000, 1, 0, 1, S_FR);  push_vec(0, OPI, 3'b000, 1, 0, 0, S_D);
        push_vec(0, OPI, 3'b000, 1, 0, 1, S_XI);  push_vec(0, OPI, 3'b000, 1, 0, 1, S_AWB);
        push_vec(0, OPR, 3'b010, 0, 0, 1, S_FR);  push_vec(0, OPR, 3'b010, 0, 0, 1, S_D);
        push_vec(0, OPR, 3'b010, 0, 0, 1, S_XR);  push_vec(0, OPR, 3'b010, 0, 0, 1, S_AWB);
        push_vec(0, OPI, 3'b111, 0, 0, 1, S_FR);  push_vec(0, OPI, 3'b111, 0, 0, 1, S_D);
        push_vec(0, OPI, 3'b111, 0, 0, 1, S_XI);  push_vec(0, OPI, 3'b111, 0, 0, 1, S_AWB);
        push_vec(0, OPI, 3'b001, 0, 0, 1, S_FR);  push_vec(0, OPI, 3'b001, 0, 0, 1, S_D);
        push_vec(0, OPI, 3'b001, 0, 0, 1, S_XI);  push_vec(0, OPI, 3'b001, 0, 0, 1, S_AWB);
        push_vec(0, OPR, 3'b110, 0, 0, 1, S_FR);  push_vec(0, OPR, 3'b110, 0, 0, 1, S_D);
        push_vec(0, OPR, 3'b110, 0, 0, 1, S_XR);  push_vec(0, OPR, 3'b110, 0, 0, 1, S_AWB);
        push_vec(0, OPR, 3'b100, 0, 0, 1, S_FR);  push_vec(0, OPR, 3'b100, 0, 0, 1, S_D);
        push_vec(0, OPR, 3'b100, 0, 0, 1, S_XR);  push_vec(0, OPR, 3'b100, 0, 0, 1, S_AWB);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_FR); push_vec(0, OPLD, 3'b010, 0, 0, 1, S_D);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MA); push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MR);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MWB);
        push_vec(0, OPST, 3'b010, 0, 0, 0, S_F);  push_vec(0, OPST, 3'b010, 0, 0, 0, S_F);
        push_vec(0, OPST, 3'b010, 0, 0, 0, S_F);  push_vec(0, OPST, 3'b010, 0, 0, 1, S_FR);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_D);  push_vec(0, OPST, 3'b010, 0, 0, 1, S_MA);
        for (int i = 0; i < 4; i++) push_vec(0, OPST, 3'b010, 0, 0, 0, S_MW);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_MWR);
        push_vec(0, OPBR, 3'b000, 0, 1, 1, S_FR); push_vec(0, OPBR, 3'b000, 0, 1, 1, S_D);
        push_vec(0, OPBR, 3'b000, 0, 1, 1, S_BR);
        push_vec(0, OPBR, 3'b001, 0, 1, 1, S_FR); push_vec(0, OPBR, 3'b001, 0, 1, 1, S_D);
        push_vec(0, OPBR, 3'b001, 0, 1, 1, S_BR);
        push_vec(0, OPBR, 3'b000, 0, 0, 1, S_FR); push_vec(0, OPBR, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPBR, 3'b000, 0, 0, 1, S_BR);
        push_vec(0, OPBR, 3'b001, 0, 0, 1, S_FR); push_vec(0, OPBR, 3'b001, 0, 0, 1, S_D);
        push_vec(0, OPBR, 3'b001, 0, 0, 1, S_BR);
        push_vec(0, OPJAL, 3'b000, 0, 0, 1, S_FR); push_vec(0, OPJAL, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPJAL, 3'b000, 0, 0, 1, S_J);  push_vec(0, OPJAL, 3'b000, 0, 0, 1, S_AWB);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_FR); push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_JA); push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_J);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_AWB);
        push_vec(0, OPLUI, 3'b000, 0, 0, 1, S_FR); push_vec(0, OPLUI, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPLUI, 3'b000, 0, 0, 1, S_LUI); push_vec(0, OPLUI, 3'b000, 0, 0, 1, S_AWB);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_FR); push_vec(0, OPLD, 3'b010, 0, 0, 1, S_D);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MA); push_vec(0, OPLD, 3'b010, 0, 0, 0, S_MR);
        push_vec(0, OPLD, 3'b010, 0, 0, 0, S_MR); push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MR);
        push_vec(0, OPLD, 3'b010, 0, 0, 1, S_MWB);
        run_queue("table");

        // Illegal opcode: absorbing fault, cleared only by reset.
        push_vec(1, OPBAD, 3'b000, 0, 0, 1, S_RST);
        push_vec(0, OPBAD, 3'b000, 0, 0, 1, S_FR);
        push_vec(0, OPBAD, 3'b000, 0, 0, 1, S_D);
        for (int i = 0; i < 100; i++)
            push_vec(0, OPBAD, 3'b000, 0, 0, 1'($urandom_range(0, 1)), S_FLT);
        push_vec(1, OPR, 3'b000, 0, 0, 1, S_RST);
        push_vec(0, OPR, 3'b000, 0, 0, 0, S_F);
        run_queue("illegal_op");

        // Branch with an unsupported funct3 faults from DECODE.
        push_vec(1, OPBR, 3'b100, 0, 0, 1, S_RST);
        push_vec(0, OPBR, 3'b100, 0, 0, 1, S_FR);
        push_vec(0, OPBR, 3'b100, 0, 0, 1, S_D);
        push_vec(0, OPBR, 3'b100, 0, 0, 1, S_FLT);
        push_vec(0, OPBR, 3'b100, 0, 0, 1, S_FLT);
        run_queue("bad_branch");

        // Fetch timeout: counter 0..4 with no ready, then fault.
        push_vec(1, OPR, 3'b000, 0, 0, 0, S_RST);
        for (int i = 0; i < 5; i++) push_vec(0, OPR, 3'b000, 0, 0, 0, S_F);
        for (int i = 0; i < 3; i++) push_vec(0, OPR, 3'b000, 0, 0, 1, S_FLT);
        run_queue("fetch_timeout");

        // Store timeout: no retire, request dropped.
        push_vec(1, OPST, 3'b010, 0, 0, 1, S_RST);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_FR);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_D);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_MA);
        for (int i = 0; i < 5; i++) push_vec(0, OPST, 3'b010, 0, 0, 0, S_MW);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_FLT);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_FLT);
        run_queue("store_timeout");

        // Reset inside JALRADR after one retirement clears the counter.
        push_vec(1, OPR, 3'b000, 0, 0, 1, S_RST);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_FR);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_XR);
        push_vec(0, OPR, 3'b000, 0, 0, 1, S_AWB);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_FR);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_D);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_JA);
        push_vec(1, OPJALR, 3'b000, 0, 0, 1, S_RST);
        push_vec(0, OPJALR, 3'b000, 0, 0, 0, S_F);
        push_vec(0, OPJALR, 3'b000, 0, 0, 1, S_FR);
        run_queue("jalr_reset");

        // Reset in the middle of a pending store drops it without retiring.
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_D);
        push_vec(0, OPST, 3'b010, 0, 0, 1, S_MA);
        push_vec(0, OPST, 3'b010, 0, 0, 0, S_MW);
        push_vec(1, OPST, 3'b010, 0, 0, 1, S_RST);
        push_vec(0, OPST, 3'b010, 0, 0, 0, S_F);
        run_queue("store_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
